// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C initiator (i2c_master_gen) and its
// quarter-period tick generator.
//   state_t     : transaction FSM states (binary encoded)
//   ACK_LVL     : SDA level that means ACK on this bus (line high)
//   NACK_LVL    : SDA level that means NACK on this bus (line low)
//   START_SLOTS : bit slots spent generating the START condition
//   BYTE_BITS   : data bits per byte on the wire
// ----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_STOP
    } state_t;

    // This bus inverts the usual I2C acknowledge sense.
    localparam logic ACK_LVL  = 1'b1;
    localparam logic NACK_LVL = 1'b0;

    localparam int START_SLOTS = 1;
    localparam int BYTE_BITS   = 8;

    // True when a 3-bit slot counter sits on the last of n slots.
    function automatic logic last_slot(input logic [2:0] cnt, input int n);
        return cnt == 3'(n - 1);
    endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// ----------------------------------------------------------------------------
// i2c_qtr_tick
// Divides clk into SCL quarter-periods of QTR cycles each and tracks which of
// the four quarters of a bit slot is current.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   en_i    : count while high; counters are held at zero while low
//   tick_o  : high on the last clk of each quarter
//   qtr_o   : current quarter index 0..3 within the bit slot
// ----------------------------------------------------------------------------
module i2c_qtr_tick #(
    parameter int QTR = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic       tick_o,
    output logic [1:0] qtr_o
);

    localparam int CW = $clog2(QTR);
    localparam logic [CW-1:0] CNT_MAX = CW'(QTR - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    qtr_q, qtr_d;

    assign tick_o = en_i && (cnt_q == CNT_MAX);
    assign qtr_o  = qtr_q;

    always_comb begin
        cnt_d = cnt_q;
        qtr_d = qtr_q;
        if (!en_i) begin
            cnt_d = '0;
            qtr_d = 2'd0;
        end else if (tick_o) begin
            cnt_d = '0;
            qtr_d = qtr_q + 2'd1;   // wraps Q3 -> Q0 at the slot boundary
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            qtr_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            qtr_q <= qtr_d;
        end
    end

endmodule

// File: rtl/i2c_master_gen.sv
// ----------------------------------------------------------------------------
// i2c_master_gen
// I2C initiator: on a start strobe it issues START, a 7-bit address plus RNW,
// then writes two bytes or reads two bytes, and finishes with STOP.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   start_stb_i  : one-cycle request, ignored while busy_o is high
//   rnw_i        : 1 = read, 0 = write (latched on start_stb_i)
//   i2c_addr_i   : 7-bit target address (latched on start_stb_i)
//   wr_data_i    : 16-bit write payload, [15:8] sent first (latched)
//   sda_in_i     : SDA as driven by the target
//   scl_o        : serial clock
//   sda_out_o    : SDA value driven by the master (1 when released)
//   sda_oe_o     : 1 = master drives SDA
//   rd_data_o    : last successfully read word, first byte in [15:8]
//   busy_o       : transaction in progress
//   done_o       : one-cycle pulse when a transaction ends
//   ack_err_o    : NACK seen during the last transaction
// Bit slot timing: SCL low in Q0-Q1, high in Q2-Q3; SDA_IN sampled at the
// Q2 tick; the FSM advances at the Q3 tick so SDA changes on entry to Q0.
// ----------------------------------------------------------------------------
module i2c_master_gen
    import i2c_pkg::*;
#(
    parameter int QTR = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_stb_i,
    input  logic        rnw_i,
    input  logic [6:0]  i2c_addr_i,
    input  logic [15:0] wr_data_i,
    input  logic        sda_in_i,
    output logic        scl_o,
    output logic        sda_out_o,
    output logic        sda_oe_o,
    output logic [15:0] rd_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        ack_err_o
);

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        byte_idx_q, byte_idx_d;
    logic        rnw_q, rnw_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] shreg_q, shreg_d;
    logic        samp_q, samp_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic [15:0] rd_data_q, rd_data_d;

    logic        tick;
    logic [1:0]  qtr;
    logic        slot_end;
    logic        sample_pt;
    logic [7:0]  addr_byte;
    logic [7:0]  wr_byte;
    logic [2:0]  tx_idx;

    i2c_qtr_tick #(
        .QTR (QTR)
    ) u_qtr_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (busy_q),
        .tick_o (tick),
        .qtr_o  (qtr)
    );

    assign slot_end  = tick && (qtr == 2'd3);
    assign sample_pt = tick && (qtr == 2'd2);
    assign addr_byte = {addr_q, rnw_q};
    assign wr_byte   = byte_idx_q ? wr_data_q[7:0] : wr_data_q[15:8];
    assign tx_idx    = 3'd7 - bit_cnt_q;     // MSB first

    // ------------------------------------------------------------------
    // Next-state logic. Transitions happen only at slot_end, so every
    // state is entered on Q0 of a fresh slot with the bit counter at 0.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        shreg_d    = shreg_q;
        samp_d     = samp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        rd_data_d  = rd_data_q;

        if (sample_pt) begin
            samp_d = sda_in_i;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_stb_i) begin
                    rnw_d      = rnw_i;
                    addr_d     = i2c_addr_i;
                    wr_data_d  = wr_data_i;
                    ack_err_d  = 1'b0;
                    busy_d     = 1'b1;
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    if (last_slot(bit_cnt_q, START_SLOTS)) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_ADDR;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (slot_end) begin
                    if (last_slot(bit_cnt_q, BYTE_BITS)) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_ADDR_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (slot_end) begin
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = 1'b0;
                    if (samp_q == ACK_LVL) begin
                        state_d = rnw_q ? ST_RD_BYTE : ST_WR_BYTE;
                    end else begin
                        ack_err_d = 1'b1;
                        state_d   = ST_STOP;
                    end
                end
            end
            ST_WR_BYTE: begin
                if (slot_end) begin
                    if (last_slot(bit_cnt_q, BYTE_BITS)) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_WR_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_WR_ACK: begin
                if (slot_end) begin
                    bit_cnt_d = 3'd0;
                    if (samp_q != ACK_LVL) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_STOP;
                    end else if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = ST_WR_BYTE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_RD_BYTE: begin
                if (sample_pt) begin
                    shreg_d = {shreg_q[14:0], sda_in_i};
                end
                if (slot_end) begin
                    if (last_slot(bit_cnt_q, BYTE_BITS)) begin
                        bit_cnt_d = 3'd0;
                        state_d   = ST_RD_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_RD_ACK: begin
                if (slot_end) begin
                    bit_cnt_d = 3'd0;
                    if (!byte_idx_q) begin
                        byte_idx_d = 1'b1;
                        state_d    = ST_RD_BYTE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (slot_end) begin
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                    // A read word is only published when every ACK was good.
                    if (rnw_q && !ack_err_q) begin
                        rd_data_d = shreg_q;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus outputs, decoded from registered state, quarter and bit index.
    // All inputs to this decode change together on the slot boundary.
    // ------------------------------------------------------------------
    always_comb begin
        scl_o     = 1'b1;
        sda_out_o = 1'b1;
        sda_oe_o  = 1'b1;
        case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                sda_out_o = ~qtr[1];            // SDA falls while SCL is high
            end
            ST_ADDR: begin
                scl_o     = qtr[1];
                sda_out_o = addr_byte[tx_idx];
            end
            ST_WR_BYTE: begin
                scl_o     = qtr[1];
                sda_out_o = wr_byte[tx_idx];
            end
            ST_ADDR_ACK, ST_WR_ACK, ST_RD_BYTE: begin
                scl_o    = qtr[1];
                sda_oe_o = 1'b0;
            end
            ST_RD_ACK: begin
                scl_o     = qtr[1];
                sda_out_o = byte_idx_q ? NACK_LVL : ACK_LVL;
            end
            ST_STOP: begin
                scl_o     = qtr[1];
                sda_out_o = (qtr == 2'd3);      // SDA rises while SCL is high
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 1'b0;
            rnw_q      <= 1'b0;
            addr_q     <= 7'd0;
            wr_data_q  <= 16'd0;
            shreg_q    <= 16'd0;
            samp_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            rd_data_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            shreg_q    <= shreg_d;
            samp_q     <= samp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ack_err_o = ack_err_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_i2c_master_gen.sv
module tb_i2c_master_gen;

    typedef struct {
        logic scl_lo;   // SCL expected during Q1
        logic oe;       // SDA_OE expected for the slot
        logic sda_a;    // SDA_OUT expected during Q1
        logic sda_b;    // SDA_OUT expected during Q3
        logic din;      // value the target drives on SDA_IN for the slot
    } slot_t;

    typedef struct {
        int          done_at;
        logic        err;
        logic [15:0] rd;
    } res_t;

    slot_t exp_q[$];
    res_t  res_q[$];

    int ncomp = 0;
    int nfail = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start2;
    logic        rnw;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic        sda_in;
    logic        on2;

    logic        scl4, sda4, oe4, busy4, done4, err4;
    logic [15:0] rd4;
    logic        scl2, sda2, oe2, busy2, done2, err2;
    logic [15:0] rd2;

    logic        scl, sda, oe, busy, done, err;
    logic [15:0] rd;

    always #5 clk = ~clk;

    i2c_master_gen #(.QTR(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_stb_i(start4), .rnw_i(rnw),
        .i2c_addr_i(addr), .wr_data_i(wdata), .sda_in_i(sda_in),
        .scl_o(scl4), .sda_out_o(sda4), .sda_oe_o(oe4), .rd_data_o(rd4),
        .busy_o(busy4), .done_o(done4), .ack_err_o(err4)
    );

    i2c_master_gen #(.QTR(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_stb_i(start2), .rnw_i(rnw),
        .i2c_addr_i(addr), .wr_data_i(wdata), .sda_in_i(sda_in),
        .scl_o(scl2), .sda_out_o(sda2), .sda_oe_o(oe2), .rd_data_o(rd2),
        .busy_o(busy2), .done_o(done2), .ack_err_o(err2)
    );

    always_comb begin
        scl  = on2 ? scl2  : scl4;
        sda  = on2 ? sda2  : sda4;
        oe   = on2 ? oe2   : oe4;
        busy = on2 ? busy2 : busy4;
        done = on2 ? done2 : done4;
        err  = on2 ? err2  : err4;
        rd   = on2 ? rd2   : rd4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        ncomp++;
        assert (obs === req) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic push(input logic a, input logic b, input logic c, input logic d, input logic e);
        slot_t s;
        s.scl_lo = a; s.oe = b; s.sda_a = c; s.sda_b = d; s.din = e;
        exp_q.push_back(s);
    endtask

    // nack_at: 0 = none, 1 = address NACK, 2 = NACK after write byte 0
    task automatic build_txn(input logic [6:0] a, input logic r, input logic [15:0] wd,
                             input logic [15:0] rdv, input int nack_at,
                             input int done_at, input logic [15:0] rd_exp);
        logic [7:0] ab;
        logic [7:0] byt;
        res_t       res;
        bit         stop_early;
        push(1, 1, 1, 0, 1);                              // START
        ab = {a, r};
        for (int i = 7; i >= 0; i--) push(0, 1, ab[i], ab[i], 1);
        push(0, 0, 1, 1, (nack_at == 1) ? 1'b0 : 1'b1);   // address ACK slot
        stop_early = (nack_at == 1);
        for (int k = 0; k < 2 && !stop_early; k++) begin
            if (r) byt = (k == 0) ? rdv[15:8] : rdv[7:0];
            else   byt = (k == 0) ? wd[15:8]  : wd[7:0];
            if (!r) begin
                for (int i = 7; i >= 0; i--) push(0, 1, byt[i], byt[i], 1);
                push(0, 0, 1, 1, (nack_at == 2 && k == 0) ? 1'b0 : 1'b1);
                if (nack_at == 2) stop_early = 1;
            end else begin
                for (int i = 7; i >= 0; i--) push(0, 0, 1, 1, byt[i]);
                push(0, 1, (k == 0), (k == 0), 1);        // master ACK then NACK
            end
        end
        push(0, 1, 0, 1, 1);                              // STOP
        res.done_at = done_at;
        res.err     = (nack_at != 0);
        res.rd      = rd_exp;
        res_q.push_back(res);
    endtask

    task automatic set_stb(input logic v);
        if (on2) start2 = v; else start4 = v;
    endtask

    task automatic run_txn(input int q, input int abort_at, input int glitch_at);
        int    n, k, r, qq, c;
        bit    seen;
        slot_t cur;
        res_t  res;
        cur = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        res = res_q.pop_front();
        set_stb(1);
        @(posedge clk); #1;
        set_stb(0);
        n = 1;
        seen = 0;
        while (n <= res.done_at + 40 && !seen) begin
            if (n == abort_at) return;
            k  = n - 1;
            r  = k % (4 * q);
            qq = r / q;
            c  = r % q;
            if (r == 0 && exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                sda_in = cur.din;
            end
            if (n == 1) begin
                chk("busy_set", busy, 1);
                chk("ack_err_cleared", err, 0);
            end
            if (n == glitch_at) begin
                set_stb(1);
                rnw = ~rnw; addr = ~addr; wdata = ~wdata;
            end
            if (n == glitch_at + 1) set_stb(0);
            if (!done && c == q - 1 && qq == 1) begin
                chk($sformatf("scl_q1@%0d", n), scl, cur.scl_lo);
                chk($sformatf("oe@%0d", n), oe, cur.oe);
                chk($sformatf("sda_q1@%0d", n), sda, cur.sda_a);
            end
            if (!done && c == q - 1 && qq == 3) begin
                chk($sformatf("scl_q3@%0d", n), scl, 1);
                chk($sformatf("sda_q3@%0d", n), sda, cur.sda_b);
            end
            if (done) begin
                seen = 1;
                chk("done_cycle", n, res.done_at);
                chk("busy_at_done", busy, 0);
                chk("ack_err", err, res.err);
                chk("rd_data", rd, res.rd);
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        chk("slots_left", exp_q.size(), 0);
        exp_q.delete();
        sda_in = 1;
        @(posedge clk); #1;
        chk("done_pulse_end", done, 0);
        $display("txn q=%0d done_at=%0d err=%0b rd=%04h", q, n, err, rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; start4 = 0; start2 = 0; rnw = 0; addr = 0; wdata = 0;
        sda_in = 1; on2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl4, 1);
        chk("rst_sda", sda4, 1);
        chk("rst_oe", oe4, 1);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_err", err4, 0);
        chk("rst_rd", rd4, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Read: address byte 0x2B, target returns 0x3C, 0xC3.
        addr = 7'h15; rnw = 1; wdata = 16'h0000;
        build_txn(addr, rnw, wdata, 16'h3CC3, 0, 465, 16'h3CC3);
        run_txn(4, 0, 0);

        // Write: address byte 0x54, data 0xA5 0x5A; RD_DATA untouched.
        addr = 7'h2A; rnw = 0; wdata = 16'hA55A;
        build_txn(addr, rnw, wdata, 16'h0000, 0, 465, 16'h3CC3);
        run_txn(4, 0, 0);

        // Address NACK on a read: 11 slots, RD_DATA untouched.
        addr = 7'h33; rnw = 1; wdata = 16'h0000;
        build_txn(addr, rnw, wdata, 16'h0000, 1, 177, 16'h3CC3);
        run_txn(4, 0, 0);

        // Write with NACK after byte 0: 20 slots.
        addr = 7'h2A; rnw = 0; wdata = 16'h1234;
        build_txn(addr, rnw, wdata, 16'h0000, 2, 321, 16'h3CC3);
        run_txn(4, 0, 0);

        // Reset in the middle of the address phase.
        addr = 7'h2A; rnw = 0; wdata = 16'hA55A;
        build_txn(addr, rnw, wdata, 16'h0000, 0, 465, 16'h3CC3);
        run_txn(4, 49, 0);
        chk("pre_rst_scl", scl4, 0);
        chk("pre_rst_busy", busy4, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_scl", scl4, 1);
        chk("mid_rst_sda", sda4, 1);
        chk("mid_rst_oe", oe4, 1);
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_rd", rd4, 0);
        $display("txn reset mid-address applied");
        exp_q.delete();
        res_q.delete();
        sda_in = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        addr = 7'h01; rnw = 1; wdata = 16'h0000;
        build_txn(addr, rnw, wdata, 16'h817E, 0, 465, 16'h817E);
        run_txn(4, 0, 0);

        // QTR=2 write with a second strobe and changed inputs while busy.
        on2 = 1;
        addr = 7'h5A; rnw = 0; wdata = 16'h0FF0;
        build_txn(addr, rnw, wdata, 16'h0000, 0, 233, 16'h0000);
        run_txn(2, 0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
